// File: rtl/fwft_fifo_ctl.sv
// First-word-fall-through FIFO with occupancy count, threshold flags,
// sticky overflow/underflow flags and a synchronous flush.
module fwft_fifo_ctl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  err_clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic          wr_acc;
  logic          rd_acc;
  logic          load;
  logic [CW-1:0] stored;
  logic [CW-1:0] count_nxt;

  // Words resident in storage and not yet in the output register; the
  // registered count excludes this cycle's write, so only settled words count.
  always_comb begin
    wr_acc    = wr_en && !full;
    rd_acc    = rd_en && !empty;
    stored    = count - CW'(!empty);
    load      = (empty || rd_acc) && (stored != '0);
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage array is never reset or flushed.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      dout         <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      dout         <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (load) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        empty  <= 1'b0;
      end else if (rd_acc) begin
        empty  <= 1'b1;
      end
      count        <= count_nxt;
      full         <= (count_nxt == CW'(DEPTH));
      almost_full  <= (count_nxt >= CW'(AF_LEVEL));
      almost_empty <= (count_nxt <= CW'(AE_LEVEL));
      // A new error event wins over a simultaneous clear.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fwft_fifo_ctl.sv
// Scoreboard bench for fwft_fifo_ctl: stimulus pushes accepted write data,
// a negedge monitor checks dout on every accepted pop.
module tb_fwft_fifo_ctl;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          err_clr = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic          empty, full, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] sb[$];
  int   mcount = 0;
  logic mvalid = 1'b0;
  logic movf = 1'b0;
  logic munf = 1'b0;

  fwft_fifo_ctl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .err_clr(err_clr),
    .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
    .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a pop is taken at the coming edge when rd_en && !empty.
  always @(negedge clk) begin
    if (!rst && !flush && rd_en && !empty) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got dout %0h expected no word", dout);
      end else begin
        if (dout !== sb[0]) begin
          fails++;
          $display("FAIL pop_data: got %0h expected %0h", dout, sb[0]);
        end
        void'(sb.pop_front());
      end
    end
  end

  task automatic check_flags();
    check("count", 32'(count), 32'(mcount));
    check("full", 32'(full), 32'(mcount == DEPTH));
    check("almost_full", 32'(almost_full), 32'(mcount >= 14));
    check("almost_empty", 32'(almost_empty), 32'(mcount <= 2));
    check("overflow", 32'(overflow), 32'(movf));
    check("underflow", 32'(underflow), 32'(munf));
  endtask

  task automatic check_reset_vals();
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_full", 32'(full), 32'h0);
    check("rst_af", 32'(almost_full), 32'h0);
    check("rst_ae", 32'(almost_empty), 32'h1);
    check("rst_count", 32'(count), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_unf", 32'(underflow), 32'h0);
  endtask

  task automatic model_clear();
    mcount = 0; mvalid = 1'b0; movf = 1'b0; munf = 1'b0;
    sb.delete();
  endtask

  // One clock: drive inputs, advance the reference model, check after the edge.
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                     input logic fl = 1'b0, input logic ec = 1'b0);
    logic acc_w, acc_r, ld;
    wr_en = w; din = d; rd_en = r; flush = fl; err_clr = ec;
    acc_w = w && (mcount != DEPTH);
    acc_r = r && mvalid;
    ld    = (!mvalid || acc_r) && ((mcount - int'(mvalid)) != 0);
    @(posedge clk);
    #1;
    if (fl) begin
      model_clear();
    end else begin
      if (acc_w) sb.push_back(d);
      mcount = mcount + int'(acc_w) - int'(acc_r);
      mvalid = ld ? 1'b1 : (acc_r ? 1'b0 : mvalid);
      movf = (w && !acc_w) ? 1'b1 : (ec ? 1'b0 : movf);
      munf = (r && !mvalid && !acc_r && !ld) || (r && !acc_r) ? 1'b1 : (ec ? 1'b0 : munf);
    end
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    check_flags();
  endtask

  initial begin
    // Reset and first-write latency
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b0;
    cyc(1'b1, 8'hA5, 1'b0);
    check("lat_empty_k", 32'(empty), 32'h1);
    cyc(1'b0, 8'h00, 1'b0);
    check("lat_empty_k1", 32'(empty), 32'h0);
    check("lat_dout_k1", 32'(dout), 32'hA5);
    cyc(1'b0, 8'h00, 1'b1);
    check("lat_drained", 32'(empty), 32'h1);

    // Fill 0x00..0x0F, then drain back-to-back
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0);
    check("fill_full", 32'(full), 32'h1);
    check("fill_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1);
    check("drain_empty", 32'(empty), 32'h1);
    check("drain_sb", 32'(sb.size()), 32'h0);

    // Full with simultaneous write and pop, then err_clr
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
    cyc(1'b1, 8'h77, 1'b1);
    check("ovf_count", 32'(count), 32'd15);
    check("ovf_flag", 32'(overflow), 32'h1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("ovf_clr", 32'(overflow), 32'h0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1);
    check("ovf_drain_sb", 32'(sb.size()), 32'h0);

    // Underflow, then write+pop at count 0
    cyc(1'b0, 8'h00, 1'b1);
    check("unf_flag", 32'(underflow), 32'h1);
    check("unf_count", 32'(count), 32'h0);
    cyc(1'b1, 8'h3C, 1'b1);
    check("unf_wr_count", 32'(count), 32'h1);
    check("unf_hold", 32'(underflow), 32'h1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    check("unf_drain", 32'(count), 32'h0);

    // Interleaved traffic across pointer wraps
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc((i % 4) != 3, 8'(8'h80 + i), ((i % 4) != 0) && mvalid);
      check("wrap_range", 32'((mcount >= 3) && (mcount <= 10)), 32'h1);
    end

    // Flush together with a write at count 9
    for (int i = 0; i < 20; i++) begin
      if (mcount == 9) break;
      if (mcount < 9) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
      else cyc(1'b0, 8'h00, mvalid);
    end
    check("pre_flush_count", 32'(count), 32'd9);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1);
    check("flush_empty", 32'(empty), 32'h1);
    check("flush_dout", 32'(dout), 32'h0);
    check("flush_count", 32'(count), 32'h0);

    // Refill, then async reset between edges
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hD0 + i), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_reset_vals();
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b1, 8'h5A, 1'b0);
    check("post_rst_count", 32'(count), 32'h1);
    check("post_rst_empty", 32'(empty), 32'h1);
    cyc(1'b0, 8'h00, 1'b0);
    check("post_rst_dout", 32'(dout), 32'h5A);
    cyc(1'b0, 8'h00, 1'b1);
    check("final_sb", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fwft_fifo_ctl.md
# fwft_fifo_ctl

Self-contained, parametrised first-word-fall-through FIFO for the shared-buffer datapath. It owns its storage array and output register, so no external plain FIFO is needed. On top of basic FWFT it adds:
- occupancy count;
- threshold flags (almost full, almost empty);
- sticky overflow/underflow error flags;
- a synchronous flush.

It sits between packet producers and the buffer arbiter, which throttles on the threshold flags.

## Interface
- DATA_WIDTH, 8: word width in bits
- ADDR_WIDTH, 4: log2 of capacity; DEPTH = 2^ADDR_WIDTH words total, including the word shown on dout
- AF_LEVEL, 2^ADDR_WIDTH-2: almost_full asserted when count >= AF_LEVEL
- AE_LEVEL, 2: almost_empty asserted when count <= AE_LEVEL

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of contents and error flags
- err_clr  in  1  synchronous clear of overflow/underflow only
- wr_en  in  1  write request
- din  in  DATA_WIDTH  write data
- rd_en  in  1  pop request (acknowledges the word currently on dout)
- dout  out  DATA_WIDTH  head word, valid whenever empty=0
- empty  out  1  no valid word on dout
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  ADDR_WIDTH+1  words accepted and not yet popped
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: pop attempted while empty

## Operation
- Write is accepted iff wr_en && !full. The word is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop is accepted iff rd_en && !empty. The output register reloads from storage if a further word is available there; otherwise empty rises.
- Rejected write: data is dropped; overflow is set. Rejected pop: no state change except underflow is set. Both flags hold until err_clr, flush or rst.
- Count update each edge:
  - +1 on accepted write only;
  - -1 on accepted pop only;
  - unchanged when both are accepted or neither is.
- Count includes a word in transit to the output register. count=1 with empty=1 is therefore legal for one cycle.
- full, almost_full and almost_empty are registered functions of the next count. They change on the same edge as count.
- Write and pop in the same cycle:
  - when full: the pop is accepted and the write is rejected (full is sampled before the edge); overflow sets.
  - when empty with count=0: the write is accepted and the pop is rejected; underflow sets.
- Pointer wrap: pointers are ADDR_WIDTH bits and wrap DEPTH-1 -> 0 silently. full/empty never depend on pointer comparison alone; count is authoritative.
- flush (priority over wr_en/rd_en/err_clr), applied at the next edge:
  - pointers and count go to 0;
  - empty=1, full=0, almost_empty=1, almost_full=0;
  - overflow=0, underflow=0, dout=0.
  - Storage contents are not cleared.
- err_clr and a new error event in the same cycle: the flag is set (the event wins).
- When empty=1 after a pop, dout holds the last popped word. This value is not meaningful.

## Timing
- Reset values (immediate on rst rise, independent of clk):
  - dout=0, empty=1, full=0, almost_full=0, almost_empty=1;
  - count=0, overflow=0, underflow=0;
  - pointers 0.
- rst deassertion is synchronised externally. The block must accept a write on the first edge after release.
- Write-to-read latency: a write into an empty FIFO at edge k gives count=1 after edge k, and empty=0 with dout=din after edge k+1.
- Pop-to-next-word latency: 0 cycles. If a second word has been resident in storage for at least one edge, it appears on dout in the same edge that consumes the first. Sustained 1 word/cycle throughput when not empty.
- Reset mid-operation discards all words. The first word written after reset follows the empty-FIFO latency.

## Test plan
- Reset/latency (DATA_WIDTH=8, ADDR_WIDTH=4): rst pulse -> all outputs at reset values. Write 0xA5 at edge 1 -> count=1 after edge 1; empty=0, dout=0xA5 after edge 2.
- Fill/drain: write 0x00..0x0F on consecutive cycles -> full=1 and count=16 after the 16th edge; almost_full first high at count=14. Pop 16 times back-to-back -> dout sequence 0x00..0x0F with no bubbles; almost_empty high at count=2; empty=1 after the last pop.
- Overflow/simultaneous: when full, drive wr_en=1 with 0x77 and rd_en=1 -> pop accepted, 0x77 dropped, count=15, overflow=1. Assert err_clr -> overflow=0 next edge.
- Underflow: when empty, drive rd_en=1 -> underflow=1, count stays 0. Drive wr_en+rd_en together when count=0 -> write accepted, count=1, underflow stays 1.
- Wrap-around: perform 40 interleaved writes and pops keeping count between 3 and 10 -> dout order matches a scoreboard exactly across pointer wraps.
- Flush/async reset: with count=9, assert flush together with wr_en -> count=0, empty=1, write ignored. Refill to 5 words, then assert rst between edges -> outputs return to reset values before the next edge.
